// File: rtl/reservation_station_pkg.sv
// Shared types for the Tomasulo reservation-station slot.
// Tag width follows from the number of stations, tag 0 meaning "no producer".
package reservation_station_pkg;

  localparam int NUM_RS = 4;
  localparam int TAG_W  = $clog2(NUM_RS + 1);

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_WAIT,
    RS_READY,
    RS_EXEC
  } rs_state_t;

  function automatic logic tag_hit(
    input logic             vld,
    input logic [TAG_W-1:0] q,
    input logic [TAG_W-1:0] tag
  );
    return vld && (q != '0) && (q == tag);
  endfunction

endpackage

// File: rtl/reservation_station_operand.sv
// One source operand of a slot: value/tag register with CDB snoop
// and an issue-time bypass from a same-cycle broadcast.
module rs_operand_slot
  import reservation_station_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              snoop_i,
  input  logic [DATA_W-1:0] issue_v_i,
  input  logic [TAG_W-1:0]  issue_q_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic [DATA_W-1:0] v_o,
  output logic [TAG_W-1:0]  q_o,
  output logic [TAG_W-1:0]  q_next_o
);

  logic [DATA_W-1:0] v_q, v_d;
  logic [TAG_W-1:0]  q_q, q_d;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (flush_i) begin
      q_d = '0;
    end else if (load_i) begin
      if (tag_hit(cdb_valid_i, issue_q_i, cdb_tag_i)) begin
        v_d = cdb_data_i;
        q_d = '0;
      end else begin
        v_d = issue_v_i;
        q_d = issue_q_i;
      end
    end else if (snoop_i && tag_hit(cdb_valid_i, q_q, cdb_tag_i)) begin
      v_d = cdb_data_i;
      q_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      q_q <= '0;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign v_o      = v_q;
  assign q_o      = q_q;
  assign q_next_o = q_d;

endmodule

// File: rtl/reservation_station.sv
// Single Tomasulo reservation-station slot: issue capture, CDB operand
// snoop, dispatch handshake to the FU and release on its own broadcast.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int MY_ADDR = 1,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  input  logic [TAG_W-1:0]  issue_addr_i,
  input  logic [OP_W-1:0]   issue_op_i,
  input  logic [DATA_W-1:0] issue_vj_i,
  input  logic [DATA_W-1:0] issue_vk_i,
  input  logic [TAG_W-1:0]  issue_qj_i,
  input  logic [TAG_W-1:0]  issue_qk_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              busy_o,
  output logic              disp_valid_o,
  input  logic              disp_ready_i,
  output logic [OP_W-1:0]   disp_op_o,
  output logic [DATA_W-1:0] disp_a_o,
  output logic [DATA_W-1:0] disp_b_o,
  output logic [TAG_W-1:0]  disp_tag_o
);

  localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(MY_ADDR);

  rs_state_t         state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              issue_sel;
  logic              accept;
  logic              snoop;
  logic              own_cdb;
  logic [TAG_W-1:0]  qj, qk;
  logic [TAG_W-1:0]  qj_next, qk_next;
  logic              srcs_ready;

  assign issue_sel  = issue_valid_i && (issue_addr_i == MY_TAG);
  assign accept     = issue_sel && (state_q == RS_IDLE) && !flush_i;
  assign snoop      = (state_q == RS_WAIT);
  assign own_cdb    = cdb_valid_i && (cdb_tag_i == MY_TAG);
  assign srcs_ready = (qj_next == '0) && (qk_next == '0);

  rs_operand_slot #(.DATA_W(DATA_W)) u_src_j (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .load_i      (accept),
    .snoop_i     (snoop),
    .issue_v_i   (issue_vj_i),
    .issue_q_i   (issue_qj_i),
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_i),
    .cdb_data_i  (cdb_data_i),
    .v_o         (disp_a_o),
    .q_o         (qj),
    .q_next_o    (qj_next)
  );

  rs_operand_slot #(.DATA_W(DATA_W)) u_src_k (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .load_i      (accept),
    .snoop_i     (snoop),
    .issue_v_i   (issue_vk_i),
    .issue_q_i   (issue_qk_i),
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_i),
    .cdb_data_i  (cdb_data_i),
    .v_o         (disp_b_o),
    .q_o         (qk),
    .q_next_o    (qk_next)
  );

  always_comb begin
    state_d = state_q;
    op_d    = accept ? issue_op_i : op_q;
    unique case (state_q)
      RS_IDLE:  if (accept) state_d = srcs_ready ? RS_READY : RS_WAIT;
      RS_WAIT:  if (srcs_ready) state_d = RS_READY;
      RS_READY: if (disp_ready_i) state_d = RS_EXEC;
      RS_EXEC:  if (own_cdb) state_d = RS_IDLE;
      default:  state_d = RS_IDLE;
    endcase
    // squash overrides every other event in the same cycle
    if (flush_i) state_d = RS_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RS_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign busy_o       = (state_q != RS_IDLE);
  assign disp_valid_o = (state_q == RS_READY);
  assign disp_op_o    = op_q;
  assign disp_tag_o   = MY_TAG;

  a_no_issue_when_busy : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(issue_sel && busy_o && !flush_i)
  ) else $error("reservation_station %0d: issue to busy slot", MY_ADDR);

  logic unused_q;
  assign unused_q = ^{qj, qk};

endmodule

// File: tb/tb_reservation_station.sv
// Directed vector table, async-reset corner and randomized run
// against a behavioural model of one reservation-station slot.
module tb_reservation_station;

  localparam int ME = 2;

  logic        clk = 0;
  logic        rst_ni = 0;
  logic        flush_i = 0;
  logic        issue_valid_i = 0;
  logic [2:0]  issue_addr_i = 0;
  logic [3:0]  issue_op_i = 0;
  logic [31:0] issue_vj_i = 0, issue_vk_i = 0;
  logic [2:0]  issue_qj_i = 0, issue_qk_i = 0;
  logic        cdb_valid_i = 0;
  logic [2:0]  cdb_tag_i = 0;
  logic [31:0] cdb_data_i = 0;
  logic        disp_ready_i = 0;
  logic        busy_o, disp_valid_o;
  logic [3:0]  disp_op_o;
  logic [31:0] disp_a_o, disp_b_o;
  logic [2:0]  disp_tag_o;

  int checks = 0;
  int errors = 0;

  reservation_station #(.MY_ADDR(ME), .DATA_W(32), .OP_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
    .issue_op_i(issue_op_i), .issue_vj_i(issue_vj_i),
    .issue_vk_i(issue_vk_i), .issue_qj_i(issue_qj_i),
    .issue_qk_i(issue_qk_i), .cdb_valid_i(cdb_valid_i),
    .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .busy_o(busy_o), .disp_valid_o(disp_valid_o),
    .disp_ready_i(disp_ready_i), .disp_op_o(disp_op_o),
    .disp_a_o(disp_a_o), .disp_b_o(disp_b_o),
    .disp_tag_o(disp_tag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic fl; logic iv; logic [2:0] ad; logic [3:0] op;
    logic [31:0] vj; logic [31:0] vk; logic [2:0] qj; logic [2:0] qk;
    logic cv; logic [2:0] ct; logic [31:0] cd; logic rdy;
    logic ebusy; logic edv; logic [3:0] eop;
    logic [31:0] ea; logic [31:0] eb;
  } vec_t;

  function automatic vec_t mk(
    input logic fl, input logic iv, input logic [2:0] ad,
    input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
    input logic [2:0] qj, input logic [2:0] qk, input logic cv,
    input logic [2:0] ct, input logic [31:0] cd, input logic rdy,
    input logic ebusy, input logic edv, input logic [3:0] eop,
    input logic [31:0] ea, input logic [31:0] eb);
    vec_t r;
    r.fl = fl; r.iv = iv; r.ad = ad; r.op = op; r.vj = vj; r.vk = vk;
    r.qj = qj; r.qk = qk; r.cv = cv; r.ct = ct; r.cd = cd; r.rdy = rdy;
    r.ebusy = ebusy; r.edv = edv; r.eop = eop; r.ea = ea; r.eb = eb;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    flush_i = v.fl; issue_valid_i = v.iv; issue_addr_i = v.ad;
    issue_op_i = v.op; issue_vj_i = v.vj; issue_vk_i = v.vk;
    issue_qj_i = v.qj; issue_qk_i = v.qk; cdb_valid_i = v.cv;
    cdb_tag_i = v.ct; cdb_data_i = v.cd; disp_ready_i = v.rdy;
  endtask

  // behavioural model: an occupied slot with pending producer tags
  bit          m_occ, m_disp;
  int          m_qj, m_qk;
  logic [31:0] m_vj, m_vk;
  logic [3:0]  m_op;

  function automatic bit hit(input int q);
    return cdb_valid_i && q != 0 && q == int'(cdb_tag_i);
  endfunction

  task automatic model_step();
    if (flush_i) begin
      m_occ = 0; m_qj = 0; m_qk = 0;
    end else if (!m_occ) begin
      if (issue_valid_i && int'(issue_addr_i) == ME) begin
        m_occ = 1; m_disp = 0; m_op = issue_op_i;
        if (hit(int'(issue_qj_i))) begin m_vj = cdb_data_i; m_qj = 0; end
        else begin m_vj = issue_vj_i; m_qj = int'(issue_qj_i); end
        if (hit(int'(issue_qk_i))) begin m_vk = cdb_data_i; m_qk = 0; end
        else begin m_vk = issue_vk_i; m_qk = int'(issue_qk_i); end
      end
    end else if (m_qj != 0 || m_qk != 0) begin
      if (hit(m_qj)) begin m_vj = cdb_data_i; m_qj = 0; end
      if (hit(m_qk)) begin m_vk = cdb_data_i; m_qk = 0; end
    end else if (!m_disp) begin
      if (disp_ready_i) m_disp = 1;
    end else if (cdb_valid_i && int'(cdb_tag_i) == ME) begin
      m_occ = 0;
    end
  endtask

  task automatic model_check();
    bit dv;
    dv = m_occ && !m_disp && m_qj == 0 && m_qk == 0;
    chk("rand_busy", 32'(busy_o), 32'(m_occ));
    chk("rand_dv", 32'(disp_valid_o), 32'(dv));
    if (dv) begin
      chk("rand_op", 32'(disp_op_o), 32'(m_op));
      chk("rand_a", disp_a_o, m_vj);
      chk("rand_b", disp_b_o, m_vk);
    end
  endtask

  vec_t tbl[19];
  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[0]  = mk(0,1,2,3,5,7,0,0,0,0,0,1, 1,1,3,5,7);
    tbl[1]  = mk(0,0,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,0,1,2,32'h99,1, 0,0,0,0,0);
    tbl[3]  = mk(0,1,2,5,0,9,3,0,0,0,0,0, 1,0,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0,0,0,1,4,32'h55,0, 1,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,1,3,32'hAB,0, 1,1,5,32'hAB,9);
    tbl[6]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 1,1,5,32'hAB,9);
    tbl[7]  = mk(0,0,0,0,0,0,0,0,1,3,32'h77,0, 1,1,5,32'hAB,9);
    tbl[8]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 1,1,5,32'hAB,9);
    tbl[9]  = mk(0,0,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0);
    tbl[10] = mk(0,0,0,0,0,0,0,0,1,2,32'h1,0, 0,0,0,0,0);
    tbl[11] = mk(0,1,2,6,0,0,4,4,1,4,32'h11,0, 1,1,6,32'h11,32'h11);
    tbl[12] = mk(0,0,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,0,0,0,1,2,0,0, 0,0,0,0,0);
    tbl[14] = mk(0,1,3,1,1,1,0,0,0,0,0,1, 0,0,0,0,0);
    tbl[15] = mk(0,1,2,2,0,3,1,0,0,0,0,0, 1,0,0,0,0);
    tbl[16] = mk(1,0,0,0,0,0,0,0,1,1,32'hCC,1, 0,0,0,0,0);
    tbl[17] = mk(0,0,0,0,0,0,0,0,1,1,32'hCC,1, 0,0,0,0,0);
    tbl[18] = mk(1,1,2,4,1,1,0,0,0,0,0,1, 0,0,0,0,0);

    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_dv", 32'(disp_valid_o), 0);
    chk("rst_op", 32'(disp_op_o), 0);
    chk("rst_a", disp_a_o, 0);
    chk("rst_b", disp_b_o, 0);
    chk("tag_const", 32'(disp_tag_o), ME);
    @(negedge clk);
    rst_ni = 1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tbl[i].ebusy));
      chk($sformatf("vec%0d_dv", i), 32'(disp_valid_o), 32'(tbl[i].edv));
      if (tbl[i].edv) begin
        chk($sformatf("vec%0d_op", i), 32'(disp_op_o), 32'(tbl[i].eop));
        chk($sformatf("vec%0d_a", i), disp_a_o, tbl[i].ea);
        chk($sformatf("vec%0d_b", i), disp_b_o, tbl[i].eb);
      end
    end

    // asynchronous reset while the instruction is executing
    drive(mk(0,1,2,9,32'h21,32'h22,0,0,0,0,0,1, 0,0,0,0,0));
    @(posedge clk); #1;
    drive(idle);
    disp_ready_i = 1;
    @(posedge clk); #1;
    chk("exec_busy", 32'(busy_o), 1);
    chk("exec_dv", 32'(disp_valid_o), 0);
    #2 rst_ni = 0;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_dv", 32'(disp_valid_o), 0);
    chk("arst_op", 32'(disp_op_o), 0);
    chk("arst_a", disp_a_o, 0);
    chk("arst_b", disp_b_o, 0);
    drive(idle);
    @(negedge clk);
    rst_ni = 1;

    m_occ = 0; m_disp = 0; m_qj = 0; m_qk = 0;
    m_vj = 0; m_vk = 0; m_op = 0;
    for (int c = 0; c < 3000; c++) begin
      flush_i = ($urandom_range(0, 19) == 0);
      issue_valid_i = ($urandom_range(0, 2) == 0);
      if (!m_occ) begin
        issue_addr_i = 3'($urandom_range(0, 4));
      end else begin
        int x;
        x = int'($urandom_range(0, 3));
        issue_addr_i = 3'(x >= ME ? x + 1 : x);
      end
      issue_op_i = 4'($urandom);
      issue_vj_i = $urandom;
      issue_vk_i = $urandom;
      issue_qj_i = $urandom_range(0, 1) ? 3'($urandom_range(1, 4)) : 3'd0;
      issue_qk_i = $urandom_range(0, 1) ? 3'($urandom_range(1, 4)) : 3'd0;
      cdb_valid_i = $urandom_range(0, 1) == 1;
      cdb_tag_i = 3'($urandom_range(0, 4));
      cdb_data_i = $urandom;
      disp_ready_i = $urandom_range(0, 1) == 1;
      model_step();
      @(posedge clk);
      #1;
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
